// File: rtl/lbm_frame_writer.sv
// lbm_frame_writer: AXI-Stream slave writing one D2Q9 frame into the lane BRAM,
// then holding the buffer until the reader releases it.
module lbm_frame_writer #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                      m00_axis_aclk,
    input  logic                      m00_axis_aresetn,
    input  logic [9*DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                      s00_axis_tvalid,
    output logic                      s00_axis_tready,
    input  logic                      s00_axis_tlast,
    input  logic [9*DATA_WIDTH/8-1:0] s00_axis_tstrb,
    output logic                      bram_we,
    output logic [ADDRESS_WIDTH-1:0]  bram_waddr,
    output logic [9*DATA_WIDTH-1:0]   bram_wdata,
    output logic                      frame_ready,
    input  logic                      frame_release,
    output logic [15:0]               frame_count,
    output logic                      tlast_err
);
    typedef enum logic [1:0] {RECV, FLUSH, HOLD} state_t;
    localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(DEPTH - 1);
    state_t state, state_n;
    logic [ADDRESS_WIDTH-1:0] cnt;
    logic hs, last_beat, unused_strb;
    assign unused_strb = ^s00_axis_tstrb;
    assign hs = s00_axis_tvalid & s00_axis_tready;
    assign last_beat = cnt == LAST;
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn)
        if (!m00_axis_aresetn) state <= RECV;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            RECV:    state_n = hs && last_beat ? FLUSH : RECV;
            FLUSH:   state_n = HOLD;
            default: state_n = frame_release ? RECV : HOLD;
        endcase
    end
    always_comb begin
        s00_axis_tready = state == RECV && m00_axis_aresetn;
        frame_ready     = state == HOLD;
    end
    // Write port is registered one cycle behind the handshake; early tlast rewinds to cell 0.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn)
        if (!m00_axis_aresetn) begin
            bram_we     <= 1'b0;
            bram_waddr  <= '0;
            bram_wdata  <= '0;
            cnt         <= '0;
            frame_count <= '0;
            tlast_err   <= 1'b0;
        end else begin
            bram_we <= hs;
            if (hs) begin
                bram_waddr <= cnt;
                bram_wdata <= s00_axis_tdata;
                cnt        <= last_beat || s00_axis_tlast ? '0 : cnt + 1'b1;
                if (last_beat != s00_axis_tlast) tlast_err <= 1'b1;
            end else if (state == HOLD && frame_release) cnt <= '0;
            if (state == FLUSH) frame_count <= frame_count + 16'd1;
        end
endmodule

// File: tb/tb_lbm_frame_writer.sv
// tb_lbm_frame_writer: directed checks of frame capture, release, tlast errors
// and mid-frame reset; lane k of each cell carries address+k.
module tb_lbm_frame_writer;
    localparam int DEPTH = 2500;
    logic         m00_axis_aclk = 1'b0;
    logic         m00_axis_aresetn = 1'b0;
    logic [143:0] s00_axis_tdata = '0;
    logic         s00_axis_tvalid = 1'b0;
    logic         s00_axis_tready;
    logic         s00_axis_tlast = 1'b0;
    logic [17:0]  s00_axis_tstrb = '1;
    logic         bram_we;
    logic [11:0]  bram_waddr;
    logic [143:0] bram_wdata;
    logic         frame_ready;
    logic         frame_release = 1'b0;
    logic [15:0]  frame_count;
    logic         tlast_err;
    int checks = 0;
    int failures = 0;

    lbm_frame_writer #(.DATA_WIDTH(16), .DEPTH(DEPTH), .ADDRESS_WIDTH(12)) dut (
        .m00_axis_aclk(m00_axis_aclk), .m00_axis_aresetn(m00_axis_aresetn),
        .s00_axis_tdata(s00_axis_tdata), .s00_axis_tvalid(s00_axis_tvalid),
        .s00_axis_tready(s00_axis_tready), .s00_axis_tlast(s00_axis_tlast),
        .s00_axis_tstrb(s00_axis_tstrb), .bram_we(bram_we), .bram_waddr(bram_waddr),
        .bram_wdata(bram_wdata), .frame_ready(frame_ready), .frame_release(frame_release),
        .frame_count(frame_count), .tlast_err(tlast_err)
    );

    always #5 m00_axis_aclk = ~m00_axis_aclk;

    function automatic logic [143:0] mk(input int a);
        logic [143:0] d;
        for (int k = 0; k < 9; k++) d[16*k +: 16] = 16'(a + k);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge m00_axis_aclk);
        #1;
    endtask

    // One beat for cell a, optionally preceded by an idle cycle (with an optional release pulse).
    task automatic beat(input int a, input logic l, input bit gap, input bit rel);
        if (gap) begin
            s00_axis_tvalid = 1'b0;
            frame_release = rel;
            tick();
            frame_release = 1'b0;
            chk("gap_we", bram_we, 0);
            chk("gap_frame_ready", frame_ready, 0);
        end
        s00_axis_tvalid = 1'b1;
        s00_axis_tdata = mk(a);
        s00_axis_tlast = l;
        chk("tready_recv", s00_axis_tready, 1);
        tick();
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast = 1'b0;
        chk("we", bram_we, 1);
        chk("waddr", bram_waddr, a);
        chk("wdata", bram_wdata, mk(a));
    endtask

    task automatic frame(input bit tl, input bit gaps, input int fc, input logic err);
        for (int i = 0; i < DEPTH; i++)
            beat(i, tl && i == DEPTH - 1, gaps && $urandom_range(1) == 1, gaps && $urandom_range(7) == 0);
        chk("flush_tready", s00_axis_tready, 0);
        chk("flush_frame_ready", frame_ready, 0);
        s00_axis_tvalid = 1'b1;
        tick();
        chk("hold_frame_ready", frame_ready, 1);
        chk("hold_frame_count", frame_count, fc);
        chk("hold_tready", s00_axis_tready, 0);
        chk("hold_tlast_err", tlast_err, err);
        repeat (3) tick();
        chk("hold_stall_we", bram_we, 0);
        chk("hold_stall_ready", frame_ready, 1);
        s00_axis_tvalid = 1'b0;
    endtask

    task automatic release_buf();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
        chk("rel_frame_ready", frame_ready, 0);
        chk("rel_tready", s00_axis_tready, 1);
    endtask

    initial begin
        s00_axis_tvalid = 1'b1;
        repeat (3) tick();
        chk("rst_tready", s00_axis_tready, 0);
        chk("rst_we", bram_we, 0);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_tlast_err", tlast_err, 0);
        chk("rst_frame_count", frame_count, 0);
        s00_axis_tvalid = 1'b0;
        m00_axis_aresetn = 1'b1;
        tick();
        frame(1'b1, 1'b0, 1, 1'b0);
        release_buf();
        frame(1'b1, 1'b0, 2, 1'b0);
        release_buf();
        frame(1'b0, 1'b1, 3, 1'b1);
        release_buf();
        m00_axis_aresetn = 1'b0;
        tick();
        m00_axis_aresetn = 1'b1;
        tick();
        chk("rerst_tlast_err", tlast_err, 0);
        chk("rerst_frame_count", frame_count, 0);
        for (int i = 0; i <= 10; i++) beat(i, i == 10, 1'b0, 1'b0);
        tick();
        chk("early_tlast_err", tlast_err, 1);
        chk("early_frame_ready", frame_ready, 0);
        chk("early_frame_count", frame_count, 0);
        frame(1'b1, 1'b0, 1, 1'b1);
        release_buf();
        for (int i = 0; i <= 1000; i++) beat(i, 1'b0, 1'b0, 1'b0);
        s00_axis_tvalid = 1'b1;
        m00_axis_aresetn = 1'b0;
        #1;
        chk("midrst_tready", s00_axis_tready, 0);
        chk("midrst_we", bram_we, 0);
        chk("midrst_waddr", bram_waddr, 0);
        chk("midrst_frame_count", frame_count, 0);
        chk("midrst_tlast_err", tlast_err, 0);
        s00_axis_tvalid = 1'b0;
        tick();
        m00_axis_aresetn = 1'b1;
        tick();
        frame(1'b1, 1'b0, 1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
